// File: rtl/xnor_parity_accum.sv
// xnor_parity_accum
//   Frame-level parity generator/checker. Each accepted WIDTH-bit word is
//   reduced to one parity bit and folded into a running accumulator. On the
//   LAST word of a frame the result is loaded into a one-entry output
//   register that uses a valid/ready handshake.
//
// Parameters
//   WIDTH   data word width (1..64)
//   CW      word counter width (1..16)
//
// Ports
//   ck       clock, rising edge
//   rstn     asynchronous reset, active low
//   clr      synchronous frame abort (drops accumulator, counter, current word)
//   vld_in   input word valid
//   rdy_out  block can accept an input word
//   d        data word
//   last     final word of frame (qualified by vld_in)
//   inv      polarity select sampled with last: 0 = XNOR, 1 = XOR
//   chk_en   check enable sampled with last
//   exp_p    expected zn sampled with last
//   vld_out  frame result valid
//   rdy_in   downstream accepts the result
//   zn       frame parity result
//   err      chk_en && (zn != exp_p), registered with zn
//   cnt      words in frame including last, saturating at 2^CW-1
module xnor_parity_accum #(
  parameter int WIDTH = 9,
  parameter int CW    = 8
) (
  input  logic             ck,
  input  logic             rstn,
  input  logic             clr,
  input  logic             vld_in,
  output logic             rdy_out,
  input  logic [WIDTH-1:0] d,
  input  logic             last,
  input  logic             inv,
  input  logic             chk_en,
  input  logic             exp_p,
  output logic             vld_out,
  input  logic             rdy_in,
  output logic             zn,
  output logic             err,
  output logic [CW-1:0]    cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  state_t          state_next;
  logic            acc;
  logic [CW-1:0]   wc;
  logic [CW-1:0]   wc_inc;
  logic            word_par;
  logic            accept;
  logic            accept_last;
  logic            frame_par;
  logic            zn_next;
  logic            err_next;

  localparam logic [CW-1:0] CntMax = '1;

  // Handshake and datapath terms. The word parity is a single XOR tree that
  // feeds the accumulator and output register directly.
  assign vld_out     = (state == FULL);
  assign rdy_out     = !clr && (!vld_out || rdy_in);
  assign accept      = vld_in && rdy_out;
  assign accept_last = accept && last;
  assign word_par    = ^d;
  assign frame_par   = acc ^ word_par;
  assign zn_next     = inv ? frame_par : ~frame_par;
  assign err_next    = chk_en && (zn_next != exp_p);
  assign wc_inc      = (wc == CntMax) ? wc : wc + 1'b1;

  // Output register state: a LAST word always (re)loads it, otherwise a pop
  // while FULL empties it.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept_last) state_next = FULL;
      FULL: begin
        if (accept_last)  state_next = FULL;
        else if (rdy_in)  state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) state <= EMPTY;
    else       state <= state_next;
  end

  // Running accumulator and word counter for the frame in progress. Abort
  // takes priority; no word can be accepted while clr is high anyway.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      acc <= 1'b0;
      wc  <= '0;
    end else if (clr) begin
      acc <= 1'b0;
      wc  <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= 1'b0;
        wc  <= '0;
      end else begin
        acc <= frame_par;
        wc  <= wc_inc;
      end
    end
  end

  // Result payload; held stable whenever no LAST word is accepted, so a
  // stalled result cannot change under the downstream consumer.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      zn  <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
    end else if (accept_last) begin
      zn  <= zn_next;
      err <= err_next;
      cnt <= wc_inc;
    end
  end

endmodule

// File: tb/tb_xnor_parity_accum.sv
// tb_xnor_parity_accum
//   Directed bench for xnor_parity_accum with WIDTH=9, CW=2 so that counter
//   saturation is reachable in a few words. Expected values are hand-derived
//   from the ones-count of each frame.
module tb_xnor_parity_accum;

  localparam int W  = 9;
  localparam int CW = 2;

  logic          ck;
  logic          rstn;
  logic          clr;
  logic          vld_in;
  logic          rdy_out;
  logic [W-1:0]  d;
  logic          last;
  logic          inv;
  logic          chk_en;
  logic          exp_p;
  logic          vld_out;
  logic          rdy_in;
  logic          zn;
  logic          err;
  logic [CW-1:0] cnt;

  int compared   = 0;
  int mismatched = 0;

  xnor_parity_accum #(.WIDTH(W), .CW(CW)) dut (
    .ck(ck), .rstn(rstn), .clr(clr), .vld_in(vld_in), .rdy_out(rdy_out),
    .d(d), .last(last), .inv(inv), .chk_en(chk_en), .exp_p(exp_p),
    .vld_out(vld_out), .rdy_in(rdy_in), .zn(zn), .err(err), .cnt(cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Present one word for a single edge, then sample 1 ns after the edge.
  task automatic send(input logic [W-1:0] dv, input logic lv, input logic iv,
                      input logic cv, input logic ev);
    vld_in = 1'b1; d = dv; last = lv; inv = iv; chk_en = cv; exp_p = ev;
    @(posedge ck); #1;
    vld_in = 1'b0; last = 1'b0;
  endtask

  task automatic idle();
    @(posedge ck); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1; #1; rstn = 1'b0; #1;
    compared++;
    if (vld_out !== 1'b0 || zn !== 1'b0 || cnt !== 2'd0 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: vld=%b zn=%b cnt=%0d err=%b, required 0 0 0 0", vld_out, zn, cnt, err);
    end
    compared++;
    if (rdy_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_rdy_out: got %b, required 1", rdy_out);
    end
    #1 rstn = 1'b1;
    idle();
    rdy_in = 1'b0;
    send(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (vld_out !== 1'b1 || zn !== 1'b1 || cnt !== 2'd1 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_frame: vld=%b zn=%b cnt=%0d err=%b, required 1 1 1 0", vld_out, zn, cnt, err);
    end
    #1 rstn = 1'b0; #1;
    compared++;
    if (vld_out !== 1'b0 || zn !== 1'b0 || cnt !== 2'd0) begin
      mismatched++;
      $display("[TB] FAIL async_reset: vld=%b zn=%b cnt=%0d, required 0 0 0", vld_out, zn, cnt);
    end
    #1 rstn = 1'b1;
    idle();
  endtask

  task automatic pop();
    rdy_in = 1'b1;
    idle();
    rdy_in = 1'b0;
    compared++;
    if (vld_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL pop_empty: vld_out=%b, required 0", vld_out);
    end
  endtask

  task automatic test_multi_word();
    send(9'h001, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9'h003, 1'b0, 1'b0, 1'b0, 1'b0);
    compared++;
    if (vld_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_frame_vld: got %b, required 0", vld_out);
    end
    send(9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (vld_out !== 1'b1 || zn !== 1'b1 || cnt !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL multi_xnor: vld=%b zn=%b cnt=%0d, required 1 1 3", vld_out, zn, cnt);
    end
    pop();
    send(9'h001, 1'b0, 1'b1, 1'b0, 1'b0);
    send(9'h003, 1'b0, 1'b1, 1'b0, 1'b0);
    send(9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0);
    compared++;
    if (vld_out !== 1'b1 || zn !== 1'b0 || cnt !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL multi_xor: vld=%b zn=%b cnt=%0d, required 1 0 3", vld_out, zn, cnt);
    end
  endtask

  // Entered with the INV=1 result (zn=0, cnt=3) still pending.
  task automatic test_backpressure();
    vld_in = 1'b1; d = 9'h001; last = 1'b1; inv = 1'b0; chk_en = 1'b0; exp_p = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge ck); #1;
      compared++;
      if (rdy_out !== 1'b0 || vld_out !== 1'b1 || zn !== 1'b0 || cnt !== 2'd3) begin
        mismatched++;
        $display("[TB] FAIL stall_hold[%0d]: rdy_out=%b vld=%b zn=%b cnt=%0d, required 0 1 0 3", i, rdy_out, vld_out, zn, cnt);
      end
    end
    rdy_in = 1'b1; #1;
    compared++;
    if (rdy_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rdy_follows_rdy_in: got %b, required 1", rdy_out);
    end
    @(posedge ck); #1;
    vld_in = 1'b0; last = 1'b0;
    compared++;
    if (vld_out !== 1'b1 || zn !== 1'b0 || cnt !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL pop_reload: vld=%b zn=%b cnt=%0d, required 1 0 1", vld_out, zn, cnt);
    end
    idle();
    rdy_in = 1'b0;
    compared++;
    if (vld_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL no_duplicate: vld_out=%b, required 0", vld_out);
    end
  endtask

  task automatic test_checker();
    send(9'h007, 1'b1, 1'b0, 1'b1, 1'b1);
    compared++;
    if (zn !== 1'b0 || err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL chk_mismatch: zn=%b err=%b, required 0 1", zn, err);
    end
    pop();
    send(9'h007, 1'b1, 1'b0, 1'b1, 1'b0);
    compared++;
    if (zn !== 1'b0 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL chk_match: zn=%b err=%b, required 0 0", zn, err);
    end
    pop();
    send(9'h007, 1'b1, 1'b0, 1'b0, 1'b1);
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL chk_off_exp1: err=%b, required 0", err);
    end
    pop();
    send(9'h007, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL chk_off_exp0: err=%b, required 0", err);
    end
  endtask

  // Entered with a result pending (zn=0, err=0, cnt=1); clr must not touch it.
  task automatic test_abort();
    clr = 1'b1;
    idle();
    clr = 1'b0;
    compared++;
    if (vld_out !== 1'b1 || zn !== 1'b0 || cnt !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL clr_keeps_result: vld=%b zn=%b cnt=%0d, required 1 0 1", vld_out, zn, cnt);
    end
    pop();
    send(9'h001, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9'h003, 1'b0, 1'b0, 1'b0, 1'b0);
    clr = 1'b1; vld_in = 1'b1; d = 9'h001; last = 1'b1; inv = 1'b0; chk_en = 1'b0;
    #1;
    compared++;
    if (rdy_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clr_rdy_out: got %b, required 0", rdy_out);
    end
    @(posedge ck); #1;
    clr = 1'b0; vld_in = 1'b0; last = 1'b0;
    compared++;
    if (vld_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL clr_drops_word: vld_out=%b, required 0", vld_out);
    end
    send(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (vld_out !== 1'b1 || zn !== 1'b1 || cnt !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL after_abort: vld=%b zn=%b cnt=%0d, required 1 1 1", vld_out, zn, cnt);
    end
    pop();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) send(9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (zn !== 1'b1 || cnt !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL sat_zero: zn=%b cnt=%0d, required 1 3", zn, cnt);
    end
    pop();
    // Odd word placed after the counter has saturated; parity must still see it.
    for (int i = 0; i < 4; i++) send(9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9'h010, 1'b0, 1'b0, 1'b0, 1'b0);
    send(9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if (zn !== 1'b0 || cnt !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL sat_parity: zn=%b cnt=%0d, required 0 3", zn, cnt);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] dv [4];
    logic         lv [4];
    logic         vx [4];
    logic         zx [4];
    logic [CW-1:0] cx [4];
    dv = '{9'h001, 9'h003, 9'h001, 9'h000};
    lv = '{1'b1, 1'b0, 1'b1, 1'b1};
    vx = '{1'b1, 1'b0, 1'b1, 1'b1};
    zx = '{1'b0, 1'b0, 1'b0, 1'b1};
    cx = '{2'd1, 2'd1, 2'd2, 2'd1};
    rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(dv[i], lv[i], 1'b0, 1'b0, 1'b0);
      compared++;
      if (vld_out !== vx[i] || (vx[i] && (zn !== zx[i] || cnt !== cx[i]))) begin
        mismatched++;
        $display("[TB] FAIL b2b[%0d]: vld=%b zn=%b cnt=%0d, required %b %b %0d", i, vld_out, zn, cnt, vx[i], zx[i], cx[i]);
      end
    end
    idle();
    rdy_in = 1'b0;
  endtask

  initial begin
    rstn = 1'b1; clr = 1'b0; vld_in = 1'b0; d = '0; last = 1'b0;
    inv = 1'b0; chk_en = 1'b0; exp_p = 1'b0; rdy_in = 1'b0;
    test_reset();
    test_multi_word();
    test_backpressure();
    test_checker();
    test_abort();
    test_saturation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/xnor_parity_accum.md
# xnor_parity_accum

Parametrised, pipelined successor to the fixed 9-input XNOR macro. Reduces each accepted WIDTH-bit word to one parity bit and accumulates parity across a multi-word frame. Delivers the frame's even/odd parity, word count and optional check error through a registered valid/ready output. Used in schematic-capture macro designs wherever a frame-level parity generator or checker is needed in place of cascaded combinational XNOR gates.

## Interface
- WIDTH, 9: data word width in bits, 1..64.
- CW, 8: word-counter width in bits, 1..16.
- CK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous reset, active low.
- CLR  input  1  synchronous frame abort; discards the accumulator and counter.
- VLD_IN  input  1  input word valid.
- RDY_OUT  output  1  block can accept an input word.
- D  input  WIDTH  data word.
- LAST  input  1  marks the final word of a frame; qualified by VLD_IN.
- INV  input  1  polarity select, sampled with LAST. 0 selects XNOR: ZN=1 when the frame's total count of ones is even. 1 selects XOR.
- CHK_EN  input  1  enables checking, sampled with LAST.
- EXP_P  input  1  expected ZN value, sampled with LAST.
- VLD_OUT  output  1  frame result valid.
- RDY_IN  input  1  downstream accepts the result.
- ZN  output  1  frame parity result.
- ERR  output  1  CHK_EN && (ZN != EXP_P), registered with ZN.
- CNT  output  CW  number of words in the frame, including the LAST word; saturates at 2^CW-1.

## Operation
- An input word is accepted on a rising CK when VLD_IN && RDY_OUT.
- RDY_OUT = !VLD_OUT || RDY_IN. This is combinational and needs no extra bubble.
- Word parity: p = XOR-reduction of D.
- ACC register, 1 bit. On accepting a non-LAST word: ACC <= ACC ^ p.
- Word counter WC, CW bits. On accepting a non-LAST word: WC <= WC+1, saturating.
- On accepting a LAST word:
  - r = ACC ^ p.
  - ZN <= INV ? r : ~r.
  - CNT <= sat(WC+1).
  - ERR <= CHK_EN && (ZN_next != EXP_P).
  - VLD_OUT <= 1.
  - ACC <= 0, WC <= 0.
- A single-word frame (LAST on the first word) is legal and yields CNT=1.
- Output register state machine:
  - EMPTY (VLD_OUT=0) moves to FULL on accepting a LAST word.
  - FULL holds ZN/ERR/CNT stable while RDY_IN=0.
  - FULL with RDY_IN=1 pops. If a LAST word is accepted in the same cycle, the register reloads and stays FULL; otherwise it returns to EMPTY.
- Input stalls only while FULL and RDY_IN=0. Non-LAST words are also stalled in that case; the behaviour is uniform.
- CLR = 1 forces ACC <= 0 and WC <= 0, and any word presented that cycle is dropped.
  - RDY_OUT is forced to 0 while CLR is high.
  - CLR does not touch the output register. A pending result remains valid until popped.
- Saturation: once WC reaches 2^CW-1 it holds. Parity keeps accumulating correctly.

## Timing
- Reset (RSTN low, asynchronous) sets:
  - ACC=0, WC=0.
  - VLD_OUT=0, ZN=0, ERR=0, CNT=0.
  - RDY_OUT follows the formula above, so RDY_OUT=1 when CLR=0.
- RSTN deassertion is synchronous to CK. The first accept can occur on the first rising edge after release.
- Latency: a LAST word accepted at edge n gives VLD_OUT=1 with a valid ZN/ERR/CNT after edge n. Throughput is one word per cycle.
- Reset mid-frame discards the partial frame and any pending result. No output follows.
- The XOR tree is a single combinational level feeding ACC/ZN. WIDTH=64 must close at the target frequency without further pipelining.

## Test plan
- Reset and defaults: WIDTH=9, single frame D=9'h000 LAST=1 INV=0 → after one edge VLD_OUT=1, ZN=1, CNT=1, ERR=0. Assert RSTN=0 → VLD_OUT=0, ZN=0, CNT=0 immediately.
- Multi-word frame: D = 9'h001, 9'h003, 9'h1FF (LAST), INV=0.
  - Total ones = 1+2+9 = 12, even, so ZN=1, CNT=3.
  - Repeat with INV=1 → ZN=0.
- Backpressure: RDY_IN=0 with a result pending.
  - RDY_OUT=0 and the outputs stay stable for 5 cycles.
  - Raise RDY_IN while presenting the next LAST word D=9'h001 → pop and reload in the same cycle, ZN=0, VLD_OUT stays 1.
- Checker: D=9'h007 LAST CHK_EN=1 EXP_P=1, INV=0.
  - ZN=0, so ERR=1.
  - With EXP_P=0 → ERR=0.
  - With CHK_EN=0 → ERR=0 for any EXP_P.
- Abort and saturation (CW=2):
  - CLR after 2 words, then one LAST word 9'h000 → CNT=1, ZN=1.
  - 6 words with all-zero data → CNT=3 (saturated), ZN=1.
- Random: WIDTH=64, 10k frames of random length 1..20 with random VLD_IN/RDY_IN → ZN, ERR, CNT match a reference model and no result is lost or duplicated.
